// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer:
// FSM state encodings, default word length and counter sizing helper.
package piso_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Bit counter width: enough to hold WIDTH-1, the index of the first bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load-side and serial-side handshake bundle of the serializer; the block
// itself connects through the slave modport, its environment through master.
interface piso_serializer_if #(
  parameter int WIDTH = piso_serializer_pkg::DEFAULT_WIDTH
);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             msb_first;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    output msb_first,
    output ser_ready,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  msb_first,
    input  ser_ready,
    output load_ready,
    output ser_out,
    output ser_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/piso_serializer_bit_down_counter.sv
// Loadable down counter that saturates at zero and flags the zero value;
// tracks how many bits of the current word remain after the one on the wire.
module bit_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; decrement is blocked at zero so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer: accepts one WIDTH-bit word in IDLE,
// streams it MSB- or LSB-first under ser_valid/ser_ready, then pulses done.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  piso_serializer_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_width_check
    $error("piso_serializer: WIDTH must lie in 2..32");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             msb_q;
  logic             accept;
  logic             xfer;
  logic             cnt_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // accept: word taken this edge; xfer: the bit on ser_out is consumed this edge.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    xfer      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.load_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.ser_ready) begin
          xfer = 1'b1;
          if (cnt_zero) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The outgoing bit always sits at the end selected by the captured order,
  // so a transfer only has to shift the register one place toward that end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      msb_q <= 1'b0;
    end else if (accept) begin
      shreg <= bus.load_data;
      msb_q <= bus.msb_first;
    end else if (xfer) begin
      if (msb_q) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
    end
  end

  bit_down_counter #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (accept),
    .load_value (LAST_IDX),
    .dec        (xfer),
    .zero       (cnt_zero)
  );

  assign bus.load_ready = (state == ST_IDLE);
  assign bus.ser_valid  = (state == ST_SHIFT);
  assign bus.done       = (state == ST_DONE);
  assign bus.busy       = (state == ST_SHIFT) || (state == ST_DONE);
  assign bus.ser_out    = (state == ST_SHIFT) && (msb_q ? shreg[WIDTH-1] : shreg[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a queue-based model of the expected bit stream
// is compared every cycle, plus literal checks on directed words.
module tb_piso_serializer;

  localparam int W = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int errors = 0;
  int checks = 0;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bits still to send, and whether the done cycle is pending/current.
  bit mq[$];
  bit m_done = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (mq.size() != 0) begin
      if (bus.ser_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
    end else if (bus.load_valid) begin
      for (int i = 0; i < W; i++)
        mq.push_back(bus.msb_first ? bus.load_data[W-1-i] : bus.load_data[i]);
    end
  end

  always @(negedge clk) begin : cmp
    bit sh;
    bit eo;
    sh = (mq.size() != 0);
    eo = sh ? mq[0] : 1'b0;
    check("m_load_ready", bus.load_ready, (!sh && !m_done));
    check("m_ser_valid",  bus.ser_valid,  sh);
    check("m_ser_out",    bus.ser_out,    eo);
    check("m_busy",       bus.busy,       (sh || m_done));
    check("m_done",       bus.done,       m_done);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, bus.load_ready, 1);
    check({tag, "_ser_valid"},  bus.ser_valid,  0);
    check({tag, "_ser_out"},    bus.ser_out,    0);
    check({tag, "_busy"},       bus.busy,       0);
    check({tag, "_done"},       bus.done,       0);
  endtask

  // Offers one word and drives the serial side until done; called at posedge+1
  // with the block idle. got collects transferred bits, first bit at the MSB.
  task automatic run_word(input logic [W-1:0] d, input bit msb, input int stall_at,
                          input int stall_len, input bit poke,
                          output logic [W-1:0] got, output int shift_cycles);
    int  nb;
    int  stall;
    bit  saw_done;
    nb = 0; stall = 0; saw_done = 0; got = '0; shift_cycles = 0;
    bus.load_data  = d;
    bus.msb_first  = msb;
    bus.load_valid = 1'b1;
    bus.ser_ready  = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 100 && !saw_done; c++) begin
      bus.load_valid = 1'b0;
      bus.ser_ready  = 1'b1;
      if (bus.ser_valid) begin
        shift_cycles++;
        if (nb == stall_at && stall < stall_len) begin
          bus.ser_ready = 1'b0;
          stall++;
          check("bp_hold_out", bus.ser_out, msb ? d[W-1-nb] : d[nb]);
        end
        if (poke && nb == 4) begin
          bus.load_valid = 1'b1;
          bus.load_data  = 8'hFF;
          bus.msb_first  = !msb;
        end
        if (bus.ser_ready) begin
          got = {got[W-2:0], bus.ser_out};
          nb++;
        end
      end else if (bus.done) begin
        saw_done = 1'b1;
        check("done_busy", bus.busy, 1);
      end
      if (!saw_done) begin
        @(posedge clk); #1;
      end
    end
    check("done_seen", saw_done, 1);
    bus.load_valid = 1'b0;
    @(posedge clk); #1;
    check("after_done_ready", bus.load_ready, 1);
    check("after_done_done",  bus.done, 0);
  endtask

  initial begin
    logic [W-1:0] got;
    int           sc;

    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.msb_first  = 1'b0;
    bus.ser_ready  = 1'b0;

    #2;
    check_reset_outputs("rst0");
    #5 reset_n = 1'b1;
    @(posedge clk); #1;

    run_word(8'hC1, 1'b1, -1, 0, 1'b0, got, sc);
    check("msb_bits", got, 8'hC1);
    check("msb_cycles", sc, 8);

    run_word(8'hC1, 1'b0, -1, 0, 1'b0, got, sc);
    check("lsb_bits", got, 8'h83);
    check("lsb_cycles", sc, 8);

    run_word(8'hC1, 1'b1, 2, 3, 1'b0, got, sc);
    check("bp_bits", got, 8'hC1);
    check("bp_cycles", sc, 11);

    run_word(8'hC1, 1'b1, -1, 0, 1'b1, got, sc);
    check("poke_bits", got, 8'hC1);
    check("poke_cycles", sc, 8);

    run_word(8'h5A, 1'b0, 0, 2, 1'b0, got, sc);
    check("lsb_5a_bits", got, 8'h5A == 8'h5A ? 8'h5A : 8'h00);

    // Abort a word after four transfers with an asynchronous reset.
    bus.load_data  = 8'hC1;
    bus.msb_first  = 1'b1;
    bus.load_valid = 1'b1;
    bus.ser_ready  = 1'b1;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid_busy_before", bus.busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    #2 reset_n = 1'b1;

    run_word(8'h01, 1'b1, -1, 0, 1'b0, got, sc);
    check("post_rst_bits", got, 8'h01);
    check("post_rst_cycles", sc, 8);

    for (int c = 0; c < 3000; c++) begin
      bus.load_valid = ($urandom_range(0, 1) == 1);
      bus.load_data  = W'($urandom);
      bus.msb_first  = ($urandom_range(0, 1) == 1);
      bus.ser_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      @(posedge clk); #1;
    end

    bus.load_valid = 1'b0;
    bus.ser_ready  = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("drain_idle", bus.load_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
